// File: rtl/oam_dma_ctrl_pkg.sv
// Shared defines and types for the OAM DMA bus controller.
// Build option DMA_ODD_ALIGN_EN adds a cycle-parity ALIGN stretch.
`ifndef OAM_DMA_DEFS
`define OAM_DMA_DEFS
`define REG_WIDTH 8
`define ADDR_WIDTH 16
`define OAM_DMA_ADDR 16'h4014
`define OAMDATA_ADDR 16'h2004
`define DMA_ST_IDLE 2'd0
`define DMA_ST_ALIGN 2'd1
`define DMA_ST_READ 2'd2
`define DMA_ST_WRITE 2'd3
`endif

package oam_dma_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = `DMA_ST_IDLE,
        ST_ALIGN = `DMA_ST_ALIGN,
        ST_READ  = `DMA_ST_READ,
        ST_WRITE = `DMA_ST_WRITE
    } dma_state_e;

    localparam int unsigned IDX_W = 9;

    // Source never crosses the page: only the low 8 index bits are used.
    function automatic logic [15:0] src_of(
        input logic [7:0]       page,
        input logic [IDX_W-1:0] idx
    );
        return {page, idx[7:0]};
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_dma_seq.sv
// OAM DMA sequencer: FSM, byte index, source page and data latch.
// With DMA_ODD_ALIGN_EN defined, ALIGN stretches on odd trigger cycles.
module oam_dma_ctrl_dma_seq
    import oam_dma_ctrl_pkg::*;
#(
    parameter int                    WIDTH      = `REG_WIDTH,
    parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = `OAM_DMA_ADDR,
    parameter int                    LEN        = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [WIDTH-1:0]      cpu_din,
    input  logic [WIDTH-1:0]      mem_dout,
    output dma_state_e            state,
    output logic                  trig,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic [WIDTH-1:0]      data_q,
    output logic                  rdy,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

    logic [7:0]       page;
    logic [IDX_W-1:0] idx;

    assign trig = (state == ST_IDLE) && cpu_we
               && (cpu_addr == TRIG_ADDR);
    assign src_addr = ADDR_WIDTH'(src_of(page, idx));

`ifdef DMA_ODD_ALIGN_EN
    logic parity;
    logic align_extra;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity <= 1'b0;
        else       parity <= ~parity;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            page   <= '0;
            idx    <= '0;
            data_q <= '0;
            rdy    <= 1'b1;
            busy   <= 1'b0;
`ifdef DMA_ODD_ALIGN_EN
            align_extra <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trig) begin
                        page  <= cpu_din[7:0];
                        idx   <= '0;
                        state <= ST_ALIGN;
                        rdy   <= 1'b0;
                        busy  <= 1'b1;
`ifdef DMA_ODD_ALIGN_EN
                        align_extra <= parity;
`endif
                    end
                end
                ST_ALIGN: begin
`ifdef DMA_ODD_ALIGN_EN
                    if (align_extra) align_extra <= 1'b0;
                    else             state <= ST_READ;
`else
                    state <= ST_READ;
`endif
                end
                ST_READ: begin
                    data_q <= mem_dout;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (idx == LAST) begin
                        state <= ST_IDLE;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_READ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA bus controller: CPU/memory muxing around the DMA sequencer.
// Build option DMA_ODD_ALIGN_EN is handled inside the sequencer.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int                    WIDTH      = `REG_WIDTH,
    parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = `OAM_DMA_ADDR,
    parameter logic [ADDR_WIDTH-1:0] DST_ADDR   = `OAMDATA_ADDR,
    parameter int                    LEN        = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [WIDTH-1:0]      cpu_din,
    output logic [WIDTH-1:0]      cpu_dout,
    output logic                  cpu_rdy,
    output logic                  dma_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_din,
    input  logic [WIDTH-1:0]      mem_dout
);

    dma_state_e            state;
    logic                  trig;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [WIDTH-1:0]      data_q;

    oam_dma_ctrl_dma_seq #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TRIG_ADDR  (TRIG_ADDR),
        .LEN        (LEN)
    ) dma_seq (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_din  (cpu_din),
        .mem_dout (mem_dout),
        .state    (state),
        .trig     (trig),
        .src_addr (src_addr),
        .data_q   (data_q),
        .rdy      (cpu_rdy),
        .busy     (dma_busy)
    );

    // The trigger write itself is swallowed, never reaching memory.
    always_comb begin
        mem_addr = cpu_addr;
        mem_we   = 1'b0;
        mem_din  = cpu_din;
        cpu_dout = '0;
        unique case (state)
            ST_IDLE: begin
                mem_we   = cpu_we & ~trig;
                cpu_dout = mem_dout;
            end
            ST_ALIGN: ;
            ST_READ: mem_addr = src_addr;
            ST_WRITE: begin
                mem_addr = DST_ADDR;
                mem_we   = 1'b1;
                mem_din  = data_q;
            end
            default: ;
        endcase
    end

endmodule
